// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the video RAM arbiter and the VGA generator:
// default address/data widths, the power-up clear fill byte, and the arbiter
// FSM state encoding.
// ----------------------------------------------------------------------------
package video_pkg;

  localparam int unsigned DEF_ADDR_W      = 13;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam logic [7:0]  DEF_CLEAR_VALUE = 8'h20;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/vram_sp.sv
// ----------------------------------------------------------------------------
// vram_sp
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, inferred as block RAM.
// One-cycle registered read; a read on a write cycle returns the old word.
// Contents are not reset.
//
// Ports:
//   i_clk    clock
//   i_we     write enable for i_addr
//   i_addr   word address
//   i_wdata  write data
//   o_q      registered read data for the address of the previous cycle
// ----------------------------------------------------------------------------
module vram_sp
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_q;

  // Read-old-data port: the read samples the array before the write lands.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/video_ram_arbiter.sv
// ----------------------------------------------------------------------------
// video_ram_arbiter
// Fixed-latency arbiter between the CPU bus and the VGA fetch path in front
// of a single-port 8 KB video RAM. Each RAM transaction takes three edges:
// IDLE decision, ACCESS (address/we registered, write commits), CAPTURE
// (RAM output registered into vga_data or cpu_rdata/cpu_ack).
//
// A VGA address change wins arbitration unless a CPU request has already
// been passed over once (cpu_wait), which bounds both latencies to 6 clocks.
//
// Optional build macro:
//   VRAM_INIT_CLEAR_EN  after reset, fill every RAM word with CLEAR_VALUE
//                       (one word per clock) before serving any request.
//
// Ports:
//   i_clk         pixel clock
//   i_rst_n       asynchronous active-low reset
//   i_vga_addr    display fetch address from the VGA generator
//   o_vga_data    registered byte for the last fetched display address
//   i_cpu_req     CPU request, held high until o_cpu_ack
//   i_cpu_we      1 = write, 0 = read
//   i_cpu_addr    CPU address
//   i_cpu_wdata   CPU write data
//   o_cpu_rdata   CPU read data, valid while o_cpu_ack is high
//   o_cpu_ack     one-cycle completion pulse
//   o_busy        high while clearing or during a RAM transaction
// ----------------------------------------------------------------------------
module video_ram_arbiter
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
`ifdef VRAM_INIT_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(DEF_CLEAR_VALUE)
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic [DATA_W-1:0] o_vga_data,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_busy
);

`ifdef VRAM_INIT_CLEAR_EN
  localparam state_e RST_STATE = CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_e            r_state;
  state_e            w_state_nxt;

  logic [ADDR_W-1:0] r_last_addr;
  logic              r_vga_pend;
  logic              r_cpu_wait;
  logic              r_op_vga;
  logic              r_op_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_vga_data;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;
  logic              r_busy;

  logic              w_vga_pend;
  logic              w_cpu_valid;
  logic              w_start_vga;
  logic              w_start_cpu;
  logic              w_set_wait;
  logic              w_capture;

  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_q;

  // A fetch is owed if one was flagged earlier or the address moved this clock.
  assign w_vga_pend  = r_vga_pend | (i_vga_addr != r_last_addr);
  // The request still high during the ack cycle belongs to the finished op.
  assign w_cpu_valid = i_cpu_req & ~r_cpu_ack;

`ifdef VRAM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;

  // Clear address walks 0..2^ADDR_W-1, one word per clock while in CLEAR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  assign w_ram_we    = (r_state == CLEAR) | ((r_state == ACCESS) & r_op_we);
  assign w_ram_addr  = (r_state == CLEAR) ? r_clr_addr : r_ram_addr;
  assign w_ram_wdata = (r_state == CLEAR) ? CLEAR_VALUE : r_ram_wdata;
`else
  assign w_ram_we    = (r_state == ACCESS) & r_op_we;
  assign w_ram_addr  = r_ram_addr;
  assign w_ram_wdata = r_ram_wdata;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and arbitration strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_vga = 1'b0;
    w_start_cpu = 1'b0;
    w_set_wait  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
`ifdef VRAM_INIT_CLEAR_EN
      CLEAR: begin
        if (r_clr_addr == {ADDR_W{1'b1}}) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      IDLE: begin
        if (w_vga_pend && !r_cpu_wait) begin
          w_start_vga = 1'b1;
          w_set_wait  = w_cpu_valid;
          w_state_nxt = ACCESS;
        end else if (w_cpu_valid) begin
          w_start_cpu = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pending/fairness flags, operation latch and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_addr <= '1;
      r_vga_pend  <= 1'b1;
      r_cpu_wait  <= 1'b0;
      r_op_vga    <= 1'b0;
      r_op_we     <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_vga_data  <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_busy      <= RST_BUSY;
    end else begin
      r_cpu_ack <= 1'b0;
      r_busy    <= (w_state_nxt != IDLE);

      if (w_start_vga) begin
        r_last_addr <= i_vga_addr;
        r_vga_pend  <= 1'b0;
        r_op_vga    <= 1'b1;
        r_op_we     <= 1'b0;
        r_ram_addr  <= i_vga_addr;
      end else if (i_vga_addr != r_last_addr) begin
        r_vga_pend <= 1'b1;
      end

      if (w_set_wait) begin
        r_cpu_wait <= 1'b1;
      end

      if (w_start_cpu) begin
        r_cpu_wait  <= 1'b0;
        r_op_vga    <= 1'b0;
        r_op_we     <= i_cpu_we;
        r_ram_addr  <= i_cpu_addr;
        r_ram_wdata <= i_cpu_wdata;
      end

      // Writes acknowledge without touching cpu_rdata.
      if (w_capture) begin
        if (r_op_vga) begin
          r_vga_data <= w_ram_q;
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_op_we) begin
            r_cpu_rdata <= w_ram_q;
          end
        end
      end
    end
  end

  vram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_vram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  assign o_vga_data  = r_vga_data;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_video_ram_arbiter
// Directed scoreboard bench for video_ram_arbiter. Stimulus pushes expected
// CPU completions (data + latency window) and expected vga_data values at
// given cycles; a monitor on the falling edge pops and compares.
// Honours VRAM_INIT_CLEAR_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_video_ram_arbiter;
  import video_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned DW = DEF_DATA_W;

`ifdef VRAM_INIT_CLEAR_EN
  localparam logic          BUSY_RST = 1'b1;
  localparam logic [DW-1:0] NB_0122  = 8'h20;
  localparam logic [DW-1:0] NB_0124  = 8'h20;
  localparam logic [DW-1:0] NB_0200  = 8'h20;
`else
  localparam logic          BUSY_RST = 1'b0;
  localparam logic [DW-1:0] NB_0122  = 8'h11;
  localparam logic [DW-1:0] NB_0124  = 8'h22;
  localparam logic [DW-1:0] NB_0200  = 8'h5A;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          busy;

  video_ram_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vga_addr  (vga_addr),
    .o_vga_data  (vga_data),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (cpu_ack),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          we;
    logic [DW-1:0] rd;
    int            issue;
    int            min_lat;
    int            max_lat;
  } cpu_exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } vga_exp_t;

  cpu_exp_t cpu_q[$];
  vga_exp_t vga_q[$];

  logic [DW-1:0] rd_hold;
  logic [AW-1:0] va [4];
  logic [DW-1:0] vd [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a CPU request now; writes expect cpu_rdata to keep the last read value.
  task automatic cpu_start(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int mn, input int mx);
    cpu_exp_t e;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    e.we      = we;
    e.rd      = we ? rd_hold : rd;
    if (!we) rd_hold = rd;
    e.issue   = cyc;
    e.min_lat = mn;
    e.max_lat = mx;
    cpu_q.push_back(e);
  endtask

  task automatic cpu_finish(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL cpu_ack_timeout: no ack within %0d cycles (cycle %0d)", budget, cyc);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int mn, input int mx);
    @(posedge clk);
    #1;
    cpu_start(we, addr, wd, rd, mn, mx);
    cpu_finish(20);
  endtask

  task automatic vga_expect(input int due, input logic [DW-1:0] data);
    vga_exp_t v;
    v.due  = due;
    v.data = data;
    vga_q.push_back(v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vga_data"},  32'(vga_data),  32'h0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),   32'h0);
    chk({tag, "_busy"},      32'(busy),      32'(BUSY_RST));
  endtask

  // Let the clear (if built in) and the forced first fetch finish.
  task automatic settle();
`ifdef VRAM_INIT_CLEAR_EN
    bit done = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL clear_timeout: busy still high (cycle %0d)", cyc);
    end
`endif
    repeat (8) @(posedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_ack_unexpected: ack with nothing outstanding (cycle %0d)", cyc);
        end else begin
          cpu_exp_t e;
          int lat;
          e   = cpu_q.pop_front();
          lat = cyc - e.issue;
          checks++;
          if (lat < e.min_lat || lat > e.max_lat) begin
            errors++;
            $display("FAIL cpu_latency: got %0d expected %0d..%0d (cycle %0d)",
                     lat, e.min_lat, e.max_lat, cyc);
          end
          chk(e.we ? "cpu_rdata_hold" : "cpu_rdata", 32'(cpu_rdata), 32'(e.rd));
        end
      end
      if (vga_q.size() != 0 && cyc >= vga_q[0].due) begin
        vga_exp_t v;
        v = vga_q.pop_front();
        chk("vga_check_cycle", 32'(cyc), 32'(v.due));
        chk("vga_data", 32'(vga_data), 32'(v.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = 13'h0123; vd[0] = 8'hA5;
    va[1] = 13'h0124; vd[1] = 8'h22;
    va[2] = 13'h0200; vd[2] = 8'h5A;
    va[3] = 13'h0122; vd[3] = 8'h11;

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vga_addr  = '0;
    rd_hold   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

`ifdef VRAM_INIT_CLEAR_EN
    fork
      begin
        int n = 0;
        for (int i = 0; i < 9000; i++) begin
          @(negedge clk);
          if (busy) n++;
          else break;
        end
        chk("clear_busy_len", 32'(n), 32'd8192);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        cpu_start(1'b0, 13'h1FFF, 8'h00, 8'h20, 8100, 8300);
        cpu_finish(9000);
      end
    join
`endif
    settle();

    // CPU writes and read-back with no VGA activity.
    @(posedge clk);
    #1;
    cpu_start(1'b1, 13'h0123, 8'hA5, 8'h00, 3, 3);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("busy_access", 32'(busy), 32'h1);
    cpu_finish(20);
    chk("busy_after_op", 32'(busy), 32'h0);
    cpu_op(1'b1, 13'h0122, 8'h11, 8'h00, 3, 3);
    cpu_op(1'b1, 13'h0124, 8'h22, 8'h00, 3, 3);
    cpu_op(1'b1, 13'h0200, 8'h5A, 8'h00, 3, 3);
    cpu_op(1'b0, 13'h0123, 8'h00, 8'hA5, 3, 3);
    cpu_op(1'b1, 13'h0300, 8'h77, 8'h00, 3, 3);

    // Idle display fetch, held for the 16-clock window.
    @(posedge clk);
    #1;
    vga_addr = 13'h0123;
    vga_expect(cyc + 3, 8'hA5);
    vga_expect(cyc + 15, 8'hA5);
    repeat (16) @(posedge clk);

    // VGA change and CPU request on the same edge: VGA first.
    #1;
    vga_addr = 13'h0122;
    vga_expect(cyc + 2, 8'hA5);
    vga_expect(cyc + 3, 8'h11);
    cpu_start(1'b0, 13'h0123, 8'h00, 8'hA5, 6, 6);
    cpu_finish(20);
    repeat (4) @(posedge clk);

    // Back-to-back CPU reads while the display address steps every 16 clocks.
    #1;
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          vga_addr = va[s];
          vga_expect(cyc + 6, vd[s]);
          vga_expect(cyc + 15, vd[s]);
          repeat (16) @(posedge clk);
          #1;
        end
      end
      begin
        for (int k = 0; k < 14; k++) begin
          cpu_start(1'b0, va[k % 4], 8'h00, vd[k % 4], 3, 6);
          cpu_finish(20);
        end
      end
    join
    repeat (4) @(posedge clk);

    // Reset while a CPU write is in ACCESS.
    #1;
    cpu_start(1'b1, 13'h0123, 8'hFF, 8'h00, 3, 3);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    cpu_q.delete();
    rd_hold = '0;
    #2;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    chk("midrst_no_ack", 32'(cpu_ack), 32'h0);
    #1;
    rst_n = 1'b1;
    settle();
    cpu_op(1'b0, 13'h0122, 8'h00, NB_0122, 3, 3);
    cpu_op(1'b0, 13'h0124, 8'h00, NB_0124, 3, 3);
    cpu_op(1'b0, 13'h0200, 8'h00, NB_0200, 3, 3);

    repeat (10) @(posedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("vga_q_drained", 32'(vga_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
